// File: rtl/top_level_if.sv
// Host-side byte interface and serial line of the UART transmitter.
interface top_level_if;
  logic [7:0] Data_In;
  logic       Byte_ready;
  logic       T_Byte;
  logic       Tx;

  modport master (
    output Data_In,
    output Byte_ready,
    output T_Byte,
    input  Tx
  );

  modport slave (
    input  Data_In,
    input  Byte_ready,
    input  T_Byte,
    output Tx
  );
endinterface

// File: rtl/top_level.sv
// 8N1 UART transmitter with one-byte holding register (double buffered).
// Define UART_TX_PARITY_EN to append an even-parity bit before STOP.
module top_level #(
  parameter int CLKS_PER_BIT = 16
) (
  input logic       clk,
  input logic       rst,
  top_level_if.slave bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [7:0]    hold_q, hold_d;
  logic          valid_q, valid_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [2:0]    bit_q, bit_d;
  logic [CW-1:0] baud_q, baud_d;
  logic          tx_q, tx_d;

  logic          baud_done;
  logic          start_ok;
  logic [7:0]    load_byte;

  assign baud_done = (baud_q == BAUD_LAST);
  assign start_ok  = bus.T_Byte &&
                     (valid_q || bus.Byte_ready);
  assign load_byte = bus.Byte_ready ? bus.Data_In
                                    : hold_q;
  assign hold_d    = bus.Byte_ready ? bus.Data_In
                                    : hold_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    par_d   = par_q;
    bit_d   = bit_q;
    valid_d = valid_q;
    tx_d    = 1'b1;
    baud_d  = (state_q == IDLE || baud_done)
              ? '0 : baud_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (start_ok) begin
          state_d = START;
          shift_d = load_byte;
          par_d   = ^load_byte;
          bit_d   = '0;
          valid_d = 1'b0;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_done) state_d = DATA;
      end
      DATA: begin
        tx_d = shift_q[0];
        if (baud_done) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_d = par_q;
        if (baud_done) state_d = STOP;
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (baud_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A byte loaded at the start edge stays pending
    if (bus.Byte_ready) valid_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      valid_q <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      bit_q   <= '0;
      baud_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.Tx = tx_q;

endmodule

// File: tb/tb_top_level.sv
// Self-checking bench for top_level: directed frame table plus
// randomized traffic against a frame-level reference model.
module tb_top_level;

  localparam int N = 16;
`ifdef UART_TX_PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   chk_en = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  top_level_if bus();

  top_level #(.CLKS_PER_BIT(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: frame bits indexed by bit period
  int          pos = -1;
  logic [10:0] frame = '1;
  logic [7:0]  m_hold = '0;
  bit          m_valid = 1'b0;
  logic        exp_tx = 1'b1;

  function automatic logic [10:0] make_frame(input logic [7:0] d);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    if (F == 11) f[9] = ^d;
    return f;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        pos = -1;
        m_valid = 1'b0;
        m_hold = '0;
        exp_tx = 1'b1;
      end else begin
        if (pos >= 0 && pos < F*N) begin
          pos++;
        end else begin
          pos = -1;
          if (bus.T_Byte && (m_valid || bus.Byte_ready)) begin
            frame = make_frame(bus.Byte_ready ? bus.Data_In
                                              : m_hold);
            pos = 0;
            m_valid = 1'b0;
          end
        end
        if (bus.Byte_ready) begin
          m_hold = bus.Data_In;
          m_valid = 1'b1;
        end
        exp_tx = (pos >= 1 && pos <= F*N)
                 ? frame[(pos-1)/N] : 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) chk("tx_cycle", 32'(bus.Tx), 32'(exp_tx));
    end
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic count_low(input int n, output int lows);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.Tx !== 1'b1) lows++;
    end
    #3;
  endtask

  // Sample each bit period at its centre after the start edge
  task automatic check_frame(input string name,
                             input logic [7:0] d);
    int k;
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    if (F == 11) f[9] = ^d;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.Tx !== 1'b0 && k < 300);
    chk({name, "_start_seen"}, 32'(bus.Tx), 32'd0);
    for (int i = 0; i < F; i++) begin
      repeat ((i == 0) ? N/2 : N) @(negedge clk);
      chk($sformatf("%s_bit%0d", name, i),
          32'(bus.Tx), 32'(f[i]));
    end
  endtask

  typedef struct {
    string      name;
    logic [7:0] data;
    bit         bypass;
    logic [7:0] exp_bits;
  } vec_t;

  vec_t vecs[6];
  int   lows;

  initial begin
    vecs[0] = '{"basic_24",  8'h24, 1'b0, 8'h24};
    vecs[1] = '{"bypass_a5", 8'hA5, 1'b1, 8'hA5};
    vecs[2] = '{"zero_00",   8'h00, 1'b0, 8'h00};
    vecs[3] = '{"bypass_ff", 8'hFF, 1'b1, 8'hFF};
    vecs[4] = '{"edge_81",   8'h81, 1'b0, 8'h81};
    vecs[5] = '{"bypass_5a", 8'h5A, 1'b1, 8'h5A};

    bus.Data_In = '0;
    bus.Byte_ready = 1'b0;
    bus.T_Byte = 1'b0;

    // Reset held for one cycle, then quiet line
    step();
    chk("reset_tx", 32'(bus.Tx), 32'd1);
    rst = 1'b0;
    chk_en = 1'b1;
    count_low(50, lows);
    chk("reset_quiet", 32'(lows), 32'd0);

    // No data pending: request alone sends nothing
    bus.T_Byte = 1'b1;
    count_low(100, lows);
    chk("no_data", 32'(lows), 32'd0);
    bus.T_Byte = 1'b0;
    step();

    foreach (vecs[v]) begin
      bus.Data_In = vecs[v].data;
      bus.Byte_ready = 1'b1;
      if (vecs[v].bypass) begin
        bus.T_Byte = 1'b1;
        step();
        bus.Byte_ready = 1'b0;
        bus.T_Byte = 1'b0;
      end else begin
        repeat (10) step();
        bus.Byte_ready = 1'b0;
        bus.T_Byte = 1'b1;
      end
      check_frame(vecs[v].name, vecs[v].exp_bits);
      count_low(40, lows);
      chk({vecs[v].name, "_no_repeat"}, 32'(lows), 32'd0);
      bus.T_Byte = 1'b0;
      step();
    end

    // Double buffer: reload mid-frame, back-to-back second frame
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.Data_In = 8'h24;
    bus.Byte_ready = 1'b1;
    step();
    bus.Byte_ready = 1'b0;
    bus.T_Byte = 1'b1;
    fork
      check_frame("dbuf_first", 8'h24);
      begin
        repeat (60) step();
        bus.Data_In = 8'hFF;
        bus.Byte_ready = 1'b1;
        step();
        bus.Byte_ready = 1'b0;
        bus.Data_In = 8'h00;
      end
    join
    check_frame("dbuf_second", 8'hFF);
    count_low(60, lows);
    chk("dbuf_no_third", 32'(lows), 32'd0);
    bus.T_Byte = 1'b0;
    step();

    // Reset mid-frame aborts and discards the pending byte
    bus.Data_In = 8'h3C;
    bus.Byte_ready = 1'b1;
    repeat (2) step();
    bus.Byte_ready = 1'b0;
    bus.T_Byte = 1'b1;
    repeat (50) step();
    rst = 1'b1;
    #1;
    chk("midrst_tx_async", 32'(bus.Tx), 32'd1);
    step();
    rst = 1'b0;
    count_low(200, lows);
    chk("midrst_no_frame", 32'(lows), 32'd0);
    bus.T_Byte = 1'b0;
    step();

    // Randomized traffic against the reference model
    for (int c = 0; c < 5000; c++) begin
      bus.Byte_ready = ($urandom_range(0, 39) == 0);
      bus.Data_In = 8'($urandom);
      if ($urandom_range(0, 99) < 4) bus.T_Byte = ~bus.T_Byte;
      rst = ($urandom_range(0, 1999) == 0);
      step();
    end
    rst = 1'b0;
    bus.Byte_ready = 1'b0;
    bus.T_Byte = 1'b0;
    repeat (F*N + 4) step();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/top_level.md
Name: top_level

Overview:
- Byte-oriented UART transmitter (8N1 framing) with a one-byte holding register and a transmit shift register.
- Host loads a byte with Byte_ready, then requests transmission with T_Byte; the serial frame appears on Tx.
- Sits between a parallel host interface and the serial line driver.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit (legal range ≥2); internal counter width is $clog2(CLKS_PER_BIT).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- Data_In  input  8  parallel byte to transmit
- Byte_ready  input  1  level; when high, Data_In is captured into the holding register
- T_Byte  input  1  level; transmit request
- Tx  output  1  serial output, registered, idle-high

Behaviour:
- Reset (async, rst=1): Tx=1, state IDLE, holding register=0, byte_valid=0, bit counter and baud counter=0. Reset mid-frame aborts the frame; Tx returns to 1 immediately.
- Holding register: on any rising edge with Byte_ready=1, it loads Data_In and byte_valid is set to 1. This is legal in every state; loading during a frame does not disturb the frame in progress (double buffering).
- States: IDLE, START, DATA, STOP.
- IDLE: Tx=1.
  - Go to START at the edge where T_Byte=1 and (byte_valid=1 or Byte_ready=1).
  - If Byte_ready=1 at that same edge, Data_In is transmitted (bypass). Otherwise the holding register is transmitted.
  - At that edge the byte is copied to the shift register and byte_valid is cleared, unless Byte_ready is also 1 at that edge.
  - T_Byte=1 with no valid byte: no action.
- START: Tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: Tx=shift_reg[0], LSB first. After each CLKS_PER_BIT cycles, shift right and increment the bit counter. After 8 bits, go to STOP.
- STOP: Tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Latency: Tx falls on the first rising edge after the edge that samples the start condition. Each bit lasts exactly CLKS_PER_BIT cycles. Frame = 10*CLKS_PER_BIT cycles.
- T_Byte is level-sensitive, but one loaded byte is sent exactly once.
  - If T_Byte is held high, a new frame starts back-to-back only if byte_valid=1 on return to IDLE (the first IDLE cycle after STOP).
  - Otherwise Tx stays 1.
- Byte_ready and T_Byte changes during START/DATA/STOP never affect the current frame.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame = 11*CLKS_PER_BIT cycles.
- Undefined: no parity bit; 10-bit 8N1 frame as above.

Test Plan:
- Reset: rst=1 for 1 cycle, inputs 0 -> Tx=1 during and after reset; no activity for 50 cycles.
- Basic frame: Data_In=8'h24, Byte_ready=1 for 10 cycles, then T_Byte=1 held and Byte_ready=0.
  - Tx per bit period: 0 | 0,0,1,0,0,1,0,0 | 1.
  - Each bit lasts exactly 16 cycles. Tx then stays 1 for the rest of the 200 cycles, with no repeat frame.
- Bypass: Byte_ready=1, T_Byte=1, Data_In=8'hA5 on the same edge in IDLE -> frame 0 | 1,0,1,0,0,1,0,1 | 1.
- Double buffer: during a frame of 8'h24, pulse Byte_ready with Data_In=8'hFF while T_Byte stays 1.
  - The 8'h24 frame is unchanged.
  - The next frame (0 | 1×8 | 1) starts back-to-back after STOP.
- No data: T_Byte=1 with byte_valid=0 after reset -> Tx stays 1.
- Mid-frame reset: assert rst during DATA -> Tx=1 immediately. Afterwards T_Byte=1 without Byte_ready gives no frame, because byte_valid was cleared.
